// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Owns the PC, drives the synchronous
// instruction memory, and feeds the instruction queue over a valid/full
// handshake with a one-entry hold buffer so backpressure never drops or
// duplicates an instruction.
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               iq_full,
  output logic               enq_valid,
  output logic [INSTR_W-1:0] enq_instr,
  output logic [PC_W-1:0]    enq_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        stall_cnt
);

  logic [PC_W-1:0]    r_pc;
  logic               r_f1_valid;
  logic [PC_W-1:0]    r_f1_pc;
  logic               r_hold_valid;
  logic [INSTR_W-1:0] r_hold_instr;
  logic [PC_W-1:0]    r_hold_pc;
  logic [15:0]        r_stall_cnt;

  logic               w_cand_valid;
  logic               w_accept;
  logic               w_capture;
  logic               w_hold_valid_nxt;
  logic               w_f1_valid_nxt;
  logic [PC_W-1:0]    w_pc_nxt;

  // Pick the enqueue candidate (hold buffer wins) and derive next-state terms.
  // When nothing is pending the hold registers are shown, so outputs are 0
  // straight out of reset.
  always_comb begin
    w_cand_valid = r_hold_valid | r_f1_valid;
    enq_instr    = r_hold_instr;
    enq_pc       = r_hold_pc;
    if (!r_hold_valid && r_f1_valid) begin
      enq_instr = imem_rdata;
      enq_pc    = r_f1_pc;
    end
    enq_valid = w_cand_valid & ~redirect;
    w_accept  = enq_valid & ~iq_full;
    // F1 word blocked by the queue with an empty hold buffer gets parked.
    w_capture = ~r_hold_valid & r_f1_valid & ~w_accept & ~redirect;
    w_hold_valid_nxt = ~redirect & ((r_hold_valid & ~w_accept) | w_capture);
    w_f1_valid_nxt   = ~w_hold_valid_nxt & ~redirect;
    // While the hold buffer stays full the address issued now is dropped, so
    // the PC must not move past it; it is refetched once the buffer drains.
    if (redirect)              w_pc_nxt = redirect_pc;
    else if (w_hold_valid_nxt) w_pc_nxt = r_pc;
    else                       w_pc_nxt = r_pc + PC_W'(1);
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_f1_valid   <= 1'b0;
      r_f1_pc      <= '0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_f1_valid   <= w_f1_valid_nxt;
      r_f1_pc      <= r_pc;
      r_hold_valid <= w_hold_valid_nxt;
      if (w_capture) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc    <= r_f1_pc;
      end
      if (enq_valid && iq_full && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit. Two instances: default
// RESET_PC=0 for flow/backpressure/redirect, and RESET_PC=0xFE for PC wrap
// and mid-stream reset. Memory word k holds 0x1000+k (0x2000+k on the second).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, iq_full, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr, enq_pc, pc;
  logic [31:0] imem_rdata, enq_instr;
  logic        enq_valid;
  logic [15:0] stall_cnt;

  logic        rst2, iq_full2, redirect2;
  logic [7:0]  redirect_pc2;
  logic [7:0]  imem_addr2, enq_pc2, pc2;
  logic [31:0] imem_rdata2, enq_instr2;
  logic        enq_valid2;
  logic [15:0] stall_cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .iq_full(iq_full), .enq_valid(enq_valid), .enq_instr(enq_instr),
    .enq_pc(enq_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .stall_cnt(stall_cnt));

  fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'hFE)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .iq_full(iq_full2), .enq_valid(enq_valid2), .enq_instr(enq_instr2),
    .enq_pc(enq_pc2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .pc(pc2), .stall_cnt(stall_cnt2));

  // Synchronous memories: data for last cycle's address.
  always @(posedge clk) begin
    imem_rdata  <= 32'h1000 + {24'h0, imem_addr};
    imem_rdata2 <= 32'h2000 + {24'h0, imem_addr2};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, settle before sampling.
  task automatic cyc(input logic full, input logic redir, input logic [7:0] rpc);
    @(posedge clk); #1;
    iq_full = full; redirect = redir; redirect_pc = rpc;
    #1;
  endtask

  // Reset dut; returns positioned in cycle 0 (first cycle after release).
  task automatic do_reset();
    rst = 1'b0; iq_full = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst enq_valid", {31'b0, enq_valid}, 32'd0);
    chk("rst enq_instr", enq_instr, 32'd0);
    chk("rst enq_pc",    {24'b0, enq_pc}, 32'd0);
    chk("rst stall_cnt", {16'b0, stall_cnt}, 32'd0);
    rst = 1'b1;
    #1;
    chk("c0 imem_addr", {24'b0, imem_addr}, 32'd0);
    chk("c0 enq_valid", {31'b0, enq_valid}, 32'd0);
  endtask

  task automatic exp_enq(input string tag, input logic [7:0] epc);
    chk({tag, " valid"}, {31'b0, enq_valid}, 32'd1);
    chk({tag, " pc"},    {24'b0, enq_pc}, {24'b0, epc});
    chk({tag, " instr"}, enq_instr, 32'h1000 + {24'b0, epc});
  endtask

  initial begin
    rst2 = 1'b1; iq_full2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 8'h00;
    rst2 = 1'b0;

    // Plain streaming.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00);
      exp_enq("stream", 8'(k - 1));
    end
    chk("stream stall", {16'b0, stall_cnt}, 32'd0);

    // One stall cycle at cycle 3.
    do_reset();
    cyc(1'b0, 1'b0, 8'h00); exp_enq("bp1 c1", 8'd0);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("bp1 c2", 8'd1);
    cyc(1'b1, 1'b0, 8'h00); exp_enq("bp1 c3", 8'd2);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("bp1 c4", 8'd2);
    for (int k = 5; k <= 7; k++) begin
      cyc(1'b0, 1'b0, 8'h00); exp_enq("bp1 after", 8'(k - 2));
    end
    chk("bp1 stall", {16'b0, stall_cnt}, 32'd1);

    // Ten stall cycles from cycle 2.
    do_reset();
    cyc(1'b0, 1'b0, 8'h00); exp_enq("bp10 c1", 8'd0);
    for (int k = 2; k <= 11; k++) begin
      cyc(1'b1, 1'b0, 8'h00);
      exp_enq("bp10 held", 8'd1);
      chk("bp10 pc", {24'b0, pc}, 32'd2);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 8'h00); exp_enq("bp10 rel", 8'(k + 1));
    end
    chk("bp10 stall", {16'b0, stall_cnt}, 32'd10);

    // Redirect at cycle 5.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b0, 8'h00); exp_enq("redir pre", 8'(k - 1));
    end
    cyc(1'b0, 1'b1, 8'h40);
    chk("redir c5 valid", {31'b0, enq_valid}, 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("redir c6 valid", {31'b0, enq_valid}, 32'd0);
    chk("redir c6 addr", {24'b0, imem_addr}, 32'h40);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("redir c7", 8'h40);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("redir c8", 8'h41);

    // Redirect while the hold buffer is full and the queue is full.
    do_reset();
    cyc(1'b0, 1'b0, 8'h00); exp_enq("rh c1", 8'd0);
    cyc(1'b1, 1'b0, 8'h00); exp_enq("rh c2", 8'd1);
    cyc(1'b1, 1'b1, 8'h80);
    chk("rh c3 valid", {31'b0, enq_valid}, 32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rh c4 valid", {31'b0, enq_valid}, 32'd0);
    chk("rh c4 addr", {24'b0, imem_addr}, 32'h80);
    cyc(1'b1, 1'b0, 8'h00); exp_enq("rh c5", 8'h80);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("rh c6", 8'h80);
    cyc(1'b0, 1'b0, 8'h00); exp_enq("rh c7", 8'h81);
    chk("rh stall", {16'b0, stall_cnt}, 32'd2);

    // RESET_PC=0xFE: wrap and mid-stream reset on the second instance.
    @(posedge clk); #1;
    chk("w rst pc", {24'b0, pc2}, 32'hFE);
    chk("w rst valid", {31'b0, enq_valid2}, 32'd0);
    rst2 = 1'b1; #1;
    chk("w c0 addr", {24'b0, imem_addr2}, 32'hFE);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #2;
      chk("w valid", {31'b0, enq_valid2}, 32'd1);
      chk("w pc", {24'b0, enq_pc2}, {24'b0, 8'(8'hFE + k)});
      chk("w instr", enq_instr2, 32'h2000 + {24'b0, 8'(8'hFE + k)});
    end
    @(posedge clk); #1;
    rst2 = 1'b0; #1;
    chk("w pre-rst valid", {31'b0, enq_valid2}, 32'd1);
    chk("w pre-rst pc", {24'b0, enq_pc2}, 32'h02);
    @(posedge clk); #1;
    rst2 = 1'b1; #1;
    chk("w post-rst valid", {31'b0, enq_valid2}, 32'd0);
    chk("w post-rst addr", {24'b0, imem_addr2}, 32'hFE);
    @(posedge clk); #2;
    chk("w restart valid", {31'b0, enq_valid2}, 32'd1);
    chk("w restart pc", {24'b0, enq_pc2}, 32'hFE);
    @(posedge clk); #2;
    chk("w restart pc2", {24'b0, enq_pc2}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: owns the program counter, drives the synchronous instruction memory address, and delivers fetched instructions to the instruction queue over a valid/full handshake. It is the producer side of the instruction queue's enqueue interface and replaces the free-running PC path that enqueues unconditionally. It honours queue backpressure without dropping or duplicating instructions, and accepts a redirect from branch/jump resolution.

## Interface

Parameters:
- PC_W, 8, width of PC and instruction memory address
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- imem_addr  out  PC_W  instruction memory address; equals pc register
- imem_rdata  in  INSTR_W  memory data for the address presented the previous cycle
- iq_full  in  1  instruction queue cannot accept this cycle
- enq_valid  out  1  enq_instr/enq_pc valid for enqueue
- enq_instr  out  INSTR_W  instruction to enqueue
- enq_pc  out  PC_W  address of enq_instr
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  PC_W  restart address
- pc  out  PC_W  next address to be fetched
- stall_cnt  out  16  saturating count of cycles with enq_valid=1 and iq_full=1

## Operation

- State: pc; F1 stage (f1_valid, f1_pc) tracking the word arriving on imem_rdata; one-entry hold buffer (hold_valid, hold_instr, hold_pc); stall_cnt.
- Candidate output: hold buffer if hold_valid, else F1 (imem_rdata, f1_pc) if f1_valid.
- enq_valid = candidate valid AND NOT redirect. Transfer (accept) = enq_valid AND NOT iq_full.
- hold_valid_next = (hold_valid AND NOT accept) OR (NOT hold_valid AND f1_valid AND NOT accept AND NOT redirect); on capture, hold loads imem_rdata/f1_pc.
- f1_valid_next = NOT hold_valid_next AND NOT redirect; f1_pc_next = pc.
- pc_next: redirect ? redirect_pc : (hold_valid_next ? pc : pc+1).
- While the hold buffer is full the address issued that cycle is discarded and refetched later; pc is never advanced past an instruction not yet delivered or held.
- PC arithmetic modulo 2^PC_W: pc = 2^PC_W-1 increments to 0.
- Redirect: clears F1 and hold in the same edge; nothing transfers in a redirect cycle; redirect has priority over every other update.
- stall_cnt increments when enq_valid AND iq_full, saturates at 16'hFFFF, cleared only by reset.
- Ordering: instructions delivered strictly in fetch order, each exactly once between redirects.

## Timing

- Reset (rst=0 at an edge): pc=RESET_PC, f1_valid=0, hold_valid=0, stall_cnt=0; outputs enq_valid=0, enq_instr=hold_instr value 0, enq_pc=0, imem_addr=RESET_PC.
- Reset asserted mid-operation discards F1 and hold contents; no enqueue occurs in the reset cycle's following cycle.
- First cycle after reset release (cycle 0): imem_addr=RESET_PC; cycle 1: enq_valid=1, enq_pc=RESET_PC.
- Steady state with iq_full=0: one instruction per cycle, enq_pc consecutive.
- Fetch latency: 1 cycle address-to-enqueue.
- Redirect asserted in cycle N: enq_valid=0 in N and N+1; cycle N+1 imem_addr=redirect_pc; cycle N+2 enq_valid=1, enq_pc=redirect_pc.
- Backpressure release: hold entry delivered the first cycle iq_full=0; next instruction follows the next cycle with no bubble.
- enq_valid, once high without redirect, stays high with stable enq_instr/enq_pc until accepted.

## Test plan

- Reset then iq_full=0, memory word k = 0x1000+k: enq_pc 0,1,2,3 on cycles 1-4, enq_instr 0x1000..0x1003, stall_cnt=0.
- iq_full=1 for cycle 3 only: enq_pc=2 held for cycles 3-4, then 3,4,… with no gap or duplicate; stall_cnt=1.
- iq_full=1 for 10 cycles from cycle 2: enq_pc=1 stable throughout, pc stays 2, stall_cnt=10, then 1,2,3 consecutively after release.
- redirect=1, redirect_pc=0x40 at cycle 5: no transfer cycles 5-6, enq_pc=0x40 at cycle 7, 0x41 at 8.
- Redirect while hold buffer full and iq_full=1: held instruction never transferred; first enqueued after release is redirect_pc.
- RESET_PC=0xFE: enq_pc 0xFE, 0xFF, 0x00, 0x01; rst=0 mid-stream yields enq_valid=0 next cycle and restart at 0xFE.
